datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 The block SHALL have these ports:
  clk  input  1  system clock; all state updates on rising edge (control FSM updates on falling edge)
  reset  input  1  synchronous, active-low reset
  LOAD_PC  input  1  load PC from IRL
  INCR_PC  input  1  increment PC
  LOAD_IRU  input  1  load IRU from mem_rdata
  LOAD_IRL  input  1  load IRL from mem_rdata
  LOAD_AC  input  1  execute the opcode in IRU; write AC and flags
  STORE_MEM  input  1  write AC to memory
  fetch  input  1  address select: 1 = PC, 0 = IRL
  mem_rdata  input  8  asynchronous-read memory data
  mem_addr  output  8  memory address
  mem_wdata  output  8  memory write data
  mem_we  output  1  memory write enable
  opcode  output  8  IRU contents, to control
  NFLG  output  1  negative flag
  ZFLG  output  1  zero flag
  CFLG  output  1  carry/borrow flag
  PC  output  8  program counter, debug
  AC  output  8  accumulator, debug

Function
REQ-002 mem_addr SHALL be PC when fetch=1, else IRL (combinational).
REQ-003 mem_wdata SHALL equal AC; mem_we SHALL equal STORE_MEM AND reset (forced 0 while reset=0).
REQ-004 PC: LOAD_PC -> PC<=IRL; else INCR_PC -> PC<=PC+1 mod 256 (FF->00); LOAD_PC has priority when both are asserted; otherwise hold.
REQ-005 IRU<=mem_rdata when LOAD_IRU=1; IRL<=mem_rdata when LOAD_IRL=1; both SHALL load in one cycle if both are asserted.
REQ-006 MDR SHALL capture mem_rdata on every rising edge with fetch=0; M denotes MDR.
REQ-007 On LOAD_AC, by IRU: 01 AC=M; 02 AC=IRL; 04 AC=~AC; 05 AC=AC+M; 06 AC=AC+IRL; 07 AC=AC-M; 08 AC=AC-IRL; 09 AC&M; 0A AC|M; 0B AC^M; 0C AC<<M[2:0]; 0D AC>>M[2:0] (logical); 0E AC&IRL; 0F AC|IRL.
REQ-008 Any other IRU value on LOAD_AC SHALL leave AC and all flags unchanged.
REQ-009 Arithmetic SHALL be 8-bit and wrap; CFLG=carry-out for add; CFLG=1 on borrow (AC<operand, unsigned) for subtract; 01 and 02 SHALL leave CFLG unchanged; all other opcodes SHALL clear CFLG.
REQ-010 On every valid LOAD_AC, NFLG<=result[7] and ZFLG<=(result==0); flags SHALL be registered and change only on LOAD_AC or reset.
REQ-011 opcode SHALL equal IRU, so it is valid at the falling edge that ends a control LOAD_IRU cycle.
REQ-012 Opcodes 03 and 10-14 SHALL affect no datapath state beyond the STORE_MEM and LOAD_PC actions driven by control.
REQ-013 Simultaneous LOAD_AC and STORE_MEM SHALL write the pre-update AC to memory.
REQ-014 M in REQ-007 SHALL be the MDR value captured on the previous rising edge with fetch=0, i.e. during control's readmem state.

Reset
REQ-015 While reset=0 at a rising edge: PC=00, IRU=00, IRL=00, AC=00, MDR=00, NFLG=0, ZFLG=1, CFLG=0.
REQ-016 A reset taking effect mid-instruction SHALL abandon the instruction; no partial AC/flag update SHALL occur on that edge, even if LOAD_AC=1.

Verification
REQ-017 Reset then fetch 02,7F then exec: AC=7F, NFLG=0, ZFLG=0, PC=02.
REQ-018 AC=7F, exec 06,01: AC=80, NFLG=1, ZFLG=0, CFLG=0. Then exec 06,80: AC=00, ZFLG=1, CFLG=1.
REQ-019 AC=05, mem[20]=07, sequence 07,20 via readmem: AC=FE, CFLG=1, NFLG=1.
REQ-020 AC=3C, 03,40: mem_addr=40, mem_we=1 for exactly one cycle, mem_wdata=3C; AC unchanged.
REQ-021 PC=FF with INCR_PC: PC=00. IRL=10 with LOAD_PC=1 and INCR_PC=1 together: PC=10.
REQ-022 reset=0 on the same edge as LOAD_AC with IRU=02, IRL=55: AC=00, ZFLG=1, and mem_we=0 throughout reset.

Source files
------------

// File: rtl/datapath_if.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_if
//  Description : Control and memory signal bundle between the accumulator
//                datapath and its control unit / memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface datapath_if;

    // Control strobes from the control unit
    logic       LOAD_PC;
    logic       INCR_PC;
    logic       LOAD_IRU;
    logic       LOAD_IRL;
    logic       LOAD_AC;
    logic       STORE_MEM;
    logic       fetch;

    // Memory side
    logic [7:0] mem_rdata;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;

    // Status and debug back to control
    logic [7:0] opcode;
    logic       NFLG;
    logic       ZFLG;
    logic       CFLG;
    logic [7:0] PC;
    logic [7:0] AC;

    // Control unit / memory side
    modport master (
        output LOAD_PC, INCR_PC, LOAD_IRU, LOAD_IRL, LOAD_AC, STORE_MEM, fetch,
        output mem_rdata,
        input  mem_addr, mem_wdata, mem_we,
        input  opcode, NFLG, ZFLG, CFLG, PC, AC
    );

    // Datapath side
    modport slave (
        input  LOAD_PC, INCR_PC, LOAD_IRU, LOAD_IRL, LOAD_AC, STORE_MEM, fetch,
        input  mem_rdata,
        output mem_addr, mem_wdata, mem_we,
        output opcode, NFLG, ZFLG, CFLG, PC, AC
    );

endinterface
`default_nettype wire

// File: rtl/datapath.sv
`default_nettype none
// ============================================================================
//  Module      : datapath
//  Description : 8-bit accumulator datapath: PC, split instruction register
//                (IRU opcode / IRL operand), memory data register, ALU and
//                N/Z/C flags. Sequenced externally by a control unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module datapath (
    input  wire logic clk,
    input  wire logic reset,      // synchronous, active-low
    datapath_if.slave bus
);

    // ------------------------------------------------------------------
    // Opcodes executed on LOAD_AC
    // ------------------------------------------------------------------
    localparam logic [7:0] OP_LDM  = 8'h01;  // AC = M
    localparam logic [7:0] OP_LDI  = 8'h02;  // AC = IRL
    localparam logic [7:0] OP_NOT  = 8'h04;  // AC = ~AC
    localparam logic [7:0] OP_ADDM = 8'h05;  // AC = AC + M
    localparam logic [7:0] OP_ADDI = 8'h06;  // AC = AC + IRL
    localparam logic [7:0] OP_SUBM = 8'h07;  // AC = AC - M
    localparam logic [7:0] OP_SUBI = 8'h08;  // AC = AC - IRL
    localparam logic [7:0] OP_ANDM = 8'h09;  // AC = AC & M
    localparam logic [7:0] OP_ORM  = 8'h0A;  // AC = AC | M
    localparam logic [7:0] OP_XORM = 8'h0B;  // AC = AC ^ M
    localparam logic [7:0] OP_SHL  = 8'h0C;  // AC = AC << M[2:0]
    localparam logic [7:0] OP_SHR  = 8'h0D;  // AC = AC >> M[2:0] (logical)
    localparam logic [7:0] OP_ANDI = 8'h0E;  // AC = AC & IRL
    localparam logic [7:0] OP_ORI  = 8'h0F;  // AC = AC | IRL

    // ------------------------------------------------------------------
    // State registers and their next-state values
    // ------------------------------------------------------------------
    logic [7:0] pc_q,  pc_d;
    logic [7:0] iru_q, iru_d;
    logic [7:0] irl_q, irl_d;
    logic [7:0] mdr_q, mdr_d;
    logic [7:0] ac_q,  ac_d;
    logic       nflg_q, nflg_d;
    logic       zflg_q, zflg_d;
    logic       cflg_q, cflg_d;

    // ALU intermediates
    logic [8:0] w_sum_m;
    logic [8:0] w_sum_l;
    logic [8:0] w_diff_m;
    logic [8:0] w_diff_l;
    logic [7:0] w_alu_res;
    logic       w_alu_carry;
    logic       w_alu_valid;

    // ------------------------------------------------------------------
    // Outputs: memory address mux, write path and status
    // ------------------------------------------------------------------
    assign bus.mem_addr  = bus.fetch ? pc_q : irl_q;
    // The write data is the registered AC, so a store issued alongside
    // LOAD_AC writes the value before the update.
    assign bus.mem_wdata = ac_q;
    // Gate the write strobe with reset so memory is never written in reset.
    assign bus.mem_we    = bus.STORE_MEM & reset;
    assign bus.opcode    = iru_q;
    assign bus.NFLG      = nflg_q;
    assign bus.ZFLG      = zflg_q;
    assign bus.CFLG      = cflg_q;
    assign bus.PC        = pc_q;
    assign bus.AC        = ac_q;

    // ------------------------------------------------------------------
    // Adders/subtractors with a ninth bit for carry and borrow
    // ------------------------------------------------------------------
    assign w_sum_m  = {1'b0, ac_q} + {1'b0, mdr_q};
    assign w_sum_l  = {1'b0, ac_q} + {1'b0, irl_q};
    assign w_diff_m = {1'b0, ac_q} - {1'b0, mdr_q};
    assign w_diff_l = {1'b0, ac_q} - {1'b0, irl_q};

    // Program counter next state: load from IRL wins over increment
    always_comb begin
        pc_d = pc_q;
        if (bus.LOAD_PC) begin
            pc_d = irl_q;
        end else if (bus.INCR_PC) begin
            pc_d = pc_q + 8'd1;
        end
    end

    // Instruction register halves and MDR capture from memory read data
    always_comb begin
        iru_d = iru_q;
        irl_d = irl_q;
        mdr_d = mdr_q;
        if (bus.LOAD_IRU) begin
            iru_d = bus.mem_rdata;
        end
        if (bus.LOAD_IRL) begin
            irl_d = bus.mem_rdata;
        end
        // MDR follows memory whenever the address comes from IRL
        if (!bus.fetch) begin
            mdr_d = bus.mem_rdata;
        end
    end

    // ALU: decode the opcode in IRU into a result and carry-out
    always_comb begin
        w_alu_res   = ac_q;
        w_alu_carry = 1'b0;
        w_alu_valid = 1'b1;
        case (iru_q)
            OP_LDM: begin
                w_alu_res   = mdr_q;
                w_alu_carry = cflg_q;   // loads preserve carry
            end
            OP_LDI: begin
                w_alu_res   = irl_q;
                w_alu_carry = cflg_q;
            end
            OP_NOT:  w_alu_res = ~ac_q;
            OP_ADDM: begin
                w_alu_res   = w_sum_m[7:0];
                w_alu_carry = w_sum_m[8];
            end
            OP_ADDI: begin
                w_alu_res   = w_sum_l[7:0];
                w_alu_carry = w_sum_l[8];
            end
            OP_SUBM: begin
                w_alu_res   = w_diff_m[7:0];
                w_alu_carry = w_diff_m[8];  // set on unsigned borrow
            end
            OP_SUBI: begin
                w_alu_res   = w_diff_l[7:0];
                w_alu_carry = w_diff_l[8];
            end
            OP_ANDM: w_alu_res = ac_q & mdr_q;
            OP_ORM:  w_alu_res = ac_q | mdr_q;
            OP_XORM: w_alu_res = ac_q ^ mdr_q;
            OP_SHL:  w_alu_res = ac_q << mdr_q[2:0];
            OP_SHR:  w_alu_res = ac_q >> mdr_q[2:0];
            OP_ANDI: w_alu_res = ac_q & irl_q;
            OP_ORI:  w_alu_res = ac_q | irl_q;
            default: begin
                // Unrecognised opcodes (incl. store/jump codes) are no-ops
                w_alu_valid = 1'b0;
                w_alu_carry = cflg_q;
            end
        endcase
    end

    // Accumulator and flag next state, committed only on a valid LOAD_AC
    always_comb begin
        ac_d   = ac_q;
        nflg_d = nflg_q;
        zflg_d = zflg_q;
        cflg_d = cflg_q;
        if (bus.LOAD_AC && w_alu_valid) begin
            ac_d   = w_alu_res;
            nflg_d = w_alu_res[7];
            zflg_d = (w_alu_res == 8'h00);
            cflg_d = w_alu_carry;
        end
    end

    // State registers; reset overrides every load strobe on the same edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q   <= 8'h00;
            iru_q  <= 8'h00;
            irl_q  <= 8'h00;
            mdr_q  <= 8'h00;
            ac_q   <= 8'h00;
            nflg_q <= 1'b0;
            zflg_q <= 1'b1;
            cflg_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            iru_q  <= iru_d;
            irl_q  <= irl_d;
            mdr_q  <= mdr_d;
            ac_q   <= ac_d;
            nflg_q <= nflg_d;
            zflg_q <= zflg_d;
            cflg_q <= cflg_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_datapath.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_datapath
//  Description : Randomised and directed bench for the accumulator datapath
//                with a behavioural reference model and queue scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath;

    localparam int LPC  = 1;
    localparam int IPC  = 2;
    localparam int LIRU = 4;
    localparam int LIRL = 8;
    localparam int LAC  = 16;
    localparam int ST   = 32;
    localparam int FCH  = 64;

    logic clk = 1'b0;
    logic reset;

    datapath_if bus ();

    datapath dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       we;
        logic [7:0] pc;
        logic [7:0] ac;
        logic [7:0] op;
        logic       n;
        logic       z;
        logic       c;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Memory seen by the DUT, and the model's own copy
    logic [7:0] mem  [256];
    int         mmem [256];

    // Reference model state (architectural registers)
    int m_pc = 0, m_iru = 0, m_irl = 0, m_ac = 0, m_mdr = 0;
    int m_n = 0, m_z = 1, m_c = 0;

    assign bus.mem_rdata = mem[bus.mem_addr];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory process: loads initial image, then services DUT writes
    initial begin : mem_proc
        #1;
        for (int i = 0; i < 256; i++) mem[i] <= 8'(mmem[i]);
        forever begin
            @(posedge clk);
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    // One control cycle: drive at the falling edge, predict, enqueue
    task automatic step(input bit rst_n, input int m);
        exp_t e;
        int a, rd, res, cy, o_pc, o_iru, o_irl, o_ac, o_mdr, sh;
        bit valid;
        @(negedge clk);
        reset         = rst_n;
        bus.LOAD_PC   = (m & LPC)  != 0;
        bus.INCR_PC   = (m & IPC)  != 0;
        bus.LOAD_IRU  = (m & LIRU) != 0;
        bus.LOAD_IRL  = (m & LIRL) != 0;
        bus.LOAD_AC   = (m & LAC)  != 0;
        bus.STORE_MEM = (m & ST)   != 0;
        bus.fetch     = (m & FCH)  != 0;

        a       = ((m & FCH) != 0) ? m_pc : m_irl;
        e.addr  = 8'(a);
        e.we    = rst_n && ((m & ST) != 0);
        e.wdata = 8'(m_ac);

        if (!rst_n) begin
            m_pc = 0; m_iru = 0; m_irl = 0; m_ac = 0; m_mdr = 0;
            m_n = 0; m_z = 1; m_c = 0;
        end else begin
            rd = mmem[a];
            o_pc = m_pc; o_iru = m_iru; o_irl = m_irl; o_ac = m_ac; o_mdr = m_mdr;
            if ((m & ST) != 0) mmem[a] = o_ac;
            if ((m & LPC) != 0)      m_pc = o_irl;
            else if ((m & IPC) != 0) m_pc = (o_pc + 1) % 256;
            if ((m & LIRU) != 0) m_iru = rd;
            if ((m & LIRL) != 0) m_irl = rd;
            if ((m & FCH) == 0)  m_mdr = rd;
            if ((m & LAC) != 0) begin
                valid = 1;
                cy    = 0;
                res   = o_ac;
                sh    = 1 << (o_mdr % 8);
                case (o_iru)
                    1:  begin res = o_mdr; cy = m_c; end
                    2:  begin res = o_irl; cy = m_c; end
                    4:  res = 255 - o_ac;
                    5:  begin res = o_ac + o_mdr; cy = (res > 255); res = res % 256; end
                    6:  begin res = o_ac + o_irl; cy = (res > 255); res = res % 256; end
                    7:  begin cy = (o_ac < o_mdr); res = (o_ac - o_mdr + 256) % 256; end
                    8:  begin cy = (o_ac < o_irl); res = (o_ac - o_irl + 256) % 256; end
                    9:  res = o_ac & o_mdr;
                    10: res = o_ac | o_mdr;
                    11: res = o_ac ^ o_mdr;
                    12: res = (o_ac * sh) % 256;
                    13: res = o_ac / sh;
                    14: res = o_ac & o_irl;
                    15: res = o_ac | o_irl;
                    default: valid = 0;
                endcase
                if (valid) begin
                    m_ac = res;
                    m_n  = (res >= 128);
                    m_z  = (res == 0);
                    m_c  = cy;
                end
            end
        end
        e.pc = 8'(m_pc); e.ac = 8'(m_ac); e.op = 8'(m_iru);
        e.n = m_n[0]; e.z = m_z[0]; e.c = m_c[0];
        q.push_back(e);
    endtask

    task automatic post();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch2();
        step(1, FCH | LIRU | IPC);
        step(1, FCH | LIRL | IPC);
    endtask

    // Monitor: compares DUT outputs against queued predictions
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q[0];
                check("mon_addr",  bus.mem_addr,  e.addr);
                check("mon_we",    {7'd0, bus.mem_we}, {7'd0, e.we});
                check("mon_wdata", bus.mem_wdata, e.wdata);
                @(posedge clk);
                #1;
                e = q.pop_front();
                check("mon_pc",  bus.PC,     e.pc);
                check("mon_ac",  bus.AC,     e.ac);
                check("mon_op",  bus.opcode, e.op);
                check("mon_nzc", {5'd0, bus.NFLG, bus.ZFLG, bus.CFLG}, {5'd0, e.n, e.z, e.c});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int m;
        reset = 1'b0;
        bus.LOAD_PC = 0; bus.INCR_PC = 0; bus.LOAD_IRU = 0; bus.LOAD_IRL = 0;
        bus.LOAD_AC = 0; bus.STORE_MEM = 0; bus.fetch = 1;

        for (int i = 0; i < 256; i++)
            mmem[i] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 16)) : int'($urandom_range(0, 255));
        mmem['h00] = 'h02; mmem['h01] = 'h7F;
        mmem['h02] = 'h06; mmem['h03] = 'h01; mmem['h04] = 'h06; mmem['h05] = 'h80;
        mmem['h06] = 'h02; mmem['h07] = 'h05; mmem['h08] = 'h07; mmem['h09] = 'h20;
        mmem['h0A] = 'h02; mmem['h0B] = 'h3C; mmem['h0C] = 'h03; mmem['h0D] = 'h40;
        mmem['h0E] = 'hFF; mmem['hFF] = 'h10; mmem['h10] = 'h02; mmem['h11] = 'h55;
        mmem['h20] = 'h07;

        // Reset state
        step(0, FCH); step(0, FCH | LAC); post();
        check("rst_pc", bus.PC, 8'h00);
        check("rst_ac", bus.AC, 8'h00);
        check("rst_op", bus.opcode, 8'h00);
        check("rst_flags", {5'd0, bus.NFLG, bus.ZFLG, bus.CFLG}, 8'b010);

        // Load immediate 7F
        fetch2(); step(1, FCH | LAC); post();
        check("ldi_ac", bus.AC, 8'h7F);
        check("ldi_pc", bus.PC, 8'h02);
        check("ldi_nz", {6'd0, bus.NFLG, bus.ZFLG}, 8'b00);

        // Add immediate: overflow into sign, then carry-out to zero
        fetch2(); step(1, FCH | LAC); post();
        check("addi1_ac", bus.AC, 8'h80);
        check("addi1_nzc", {5'd0, bus.NFLG, bus.ZFLG, bus.CFLG}, 8'b100);
        fetch2(); step(1, FCH | LAC); post();
        check("addi2_ac", bus.AC, 8'h00);
        check("addi2_zc", {6'd0, bus.ZFLG, bus.CFLG}, 8'b11);

        // Subtract from memory through readmem: 05 - 07
        fetch2(); step(1, FCH | LAC);
        fetch2(); step(1, 0); step(1, FCH | LAC); post();
        check("subm_ac", bus.AC, 8'hFE);
        check("subm_nc", {6'd0, bus.NFLG, bus.CFLG}, 8'b11);

        // Store 3C to address 40 (LOAD_AC with store opcode is a no-op)
        fetch2(); step(1, FCH | LAC);
        fetch2(); step(1, ST | LAC);
        #2;
        check("st_addr", bus.mem_addr, 8'h40);
        check("st_we", {7'd0, bus.mem_we}, 8'd1);
        check("st_wdata", bus.mem_wdata, 8'h3C);
        post();
        check("st_ac", bus.AC, 8'h3C);
        check("st_mem", mem[8'h40], 8'h3C);
        step(1, FCH);
        #2;
        check("st_we_off", {7'd0, bus.mem_we}, 8'd0);

        // PC wrap and LOAD_PC priority over INCR_PC
        step(1, FCH | LIRL | IPC); step(1, LPC | FCH); post();
        check("pc_ff", bus.PC, 8'hFF);
        step(1, IPC | FCH); post();
        check("pc_wrap", bus.PC, 8'h00);
        step(1, LIRL); step(1, LPC | IPC | FCH); post();
        check("pc_prio", bus.PC, 8'h10);

        // Reset on the same edge as LOAD_AC (and a store)
        fetch2(); step(0, FCH | LAC | ST);
        #2;
        check("rst_we", {7'd0, bus.mem_we}, 8'd0);
        post();
        check("rst_exec_ac", bus.AC, 8'h00);
        check("rst_exec_z", {7'd0, bus.ZFLG}, 8'd1);

        // Random phase
        repeat (600) begin
            m = 0;
            if ($urandom_range(0, 7) == 0) m |= LPC;
            if ($urandom_range(0, 1) == 0) m |= IPC;
            if ($urandom_range(0, 2) == 0) m |= LIRU;
            if ($urandom_range(0, 2) == 0) m |= LIRL;
            if ($urandom_range(0, 1) == 0) m |= LAC;
            if ($urandom_range(0, 5) == 0) m |= ST;
            if ($urandom_range(0, 1) == 0) m |= FCH;
            step($urandom_range(0, 39) != 0, m);
        end
        step(1, FCH);
        repeat (3) @(negedge clk);
        check("drain", 8'(q.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
